// File: rtl/alu_arbiter_if.sv
// Bundle of both requester channels and the shared-ALU port for alu_arbiter.
// The arbiter takes the slave side; the requesters and the ALU sit on the master side.
interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [3:0]       req0_op;
   logic             rsp0_valid;
   logic [WIDTH-1:0] rsp0_data;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [3:0]       req1_op;
   logic             rsp1_valid;
   logic [WIDTH-1:0] rsp1_data;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_out;
   logic             grant_id;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  alu_out,
      output req0_ready, rsp0_valid, rsp0_data,
      output req1_ready, rsp1_valid, rsp1_data,
      output alu_a, alu_b, alu_op, grant_id
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output alu_out,
      input  req0_ready, rsp0_valid, rsp0_data,
      input  req1_ready, rsp1_valid, rsp1_data,
      input  alu_a, alu_b, alu_op, grant_id
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU, result latency 1.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
   parameter int         WIDTH   = 32,
   parameter logic [3:0] IDLE_OP = 4'b0000
) (
   input  logic         clk,
   input  logic         rst,
   alu_arbiter_if.slave bus
);
   logic [1:0]       req_valid;
   logic [WIDTH-1:0] req_a  [2];
   logic [WIDTH-1:0] req_b  [2];
   logic [3:0]       req_op [2];
   logic [1:0]       grant;

   assign req_valid = {bus.req1_valid, bus.req0_valid};
   assign req_a[0]  = bus.req0_a;
   assign req_a[1]  = bus.req1_a;
   assign req_b[0]  = bus.req0_b;
   assign req_b[1]  = bus.req1_b;
   assign req_op[0] = bus.req0_op;
   assign req_op[1] = bus.req1_op;

`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      grant = 2'b00;
      if (!rst) begin
         if (req_valid[0]) begin
            grant = 2'b01;
         end else if (req_valid[1]) begin
            grant = 2'b10;
         end
      end
   end
`else
   logic last_grant_q;
   logic last_grant_d;

   // Grant is gated by rst so a reset cycle never transfers or produces a response.
   always_comb begin
      grant = 2'b00;
      if (!rst) begin
         if (req_valid == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
         end else begin
            grant = req_valid;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (grant[0]) begin
         last_grant_d = 1'b0;
      end else if (grant[1]) begin
         last_grant_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];
   assign bus.grant_id   = grant[1];

   always_comb begin
      bus.alu_a  = '0;
      bus.alu_b  = '0;
      bus.alu_op = IDLE_OP;
      if (grant[0]) begin
         bus.alu_a  = req_a[0];
         bus.alu_b  = req_b[0];
         bus.alu_op = req_op[0];
      end else if (grant[1]) begin
         bus.alu_a  = req_a[1];
         bus.alu_b  = req_b[1];
         bus.alu_op = req_op[1];
      end
   end

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : gen_rsp
      logic             rsp_valid_q;
      logic             rsp_valid_d;
      logic [WIDTH-1:0] rsp_data_q;
      logic [WIDTH-1:0] rsp_data_d;

      // Each response register only moves on its own requester's grant.
      always_comb begin
         rsp_valid_d = grant[gi];
         rsp_data_d  = rsp_data_q;
         if (grant[gi]) begin
            rsp_data_d = bus.alu_out;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
         end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
         end
      end

      if (gi == 0) begin : g_port0
         assign bus.rsp0_valid = rsp_valid_q;
         assign bus.rsp0_data  = rsp_data_q;
      end else begin : g_port1
         assign bus.rsp1_valid = rsp_valid_q;
         assign bus.rsp1_data  = rsp_data_q;
      end
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL match the shared ALU datapath width.
REQ-002 Parameter IDLE_OP, default 4'b0000, ALU op code SHALL be driven when no request is granted (nop/sll).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-008 req0_op  input  4  requester 0 ALU op code.
REQ-009 rsp0_valid  output  1  requester 0 result valid, one-cycle pulse.
REQ-010 rsp0_data  output  WIDTH  requester 0 result.
REQ-011 req1_valid, req1_ready, req1_a, req1_b, req1_op, rsp1_valid, rsp1_data  SHALL mirror REQ-005..REQ-010 for requester 1.
REQ-012 alu_a, alu_b  output  WIDTH each  operands to the shared ALU.
REQ-013 alu_op  output  4  op code to the shared ALU.
REQ-014 alu_out  input  WIDTH  combinational result from the shared ALU.
REQ-015 grant_id  output  1  index of the requester granted this cycle; 0 when idle.

Function
REQ-016 At most one operation SHALL be granted per cycle; grant SHALL be computed combinationally from reqN_valid and the last_grant register.
REQ-017 reqN_ready SHALL be high only for the granted requester, in the same cycle as its reqN_valid; a transfer occurs when valid and ready are both high.
REQ-018 Granted requester's a/b/op SHALL drive alu_a/alu_b/alu_op in the grant cycle; with no grant, alu_a = alu_b = 0 and alu_op = IDLE_OP.
REQ-019 alu_out SHALL be registered into rspN_data of the granted requester at the end of the grant cycle; rspN_valid SHALL be high exactly the following cycle (latency 1).
REQ-020 rspN_data SHALL hold its last value until the next response for that requester; the other requester's rsp_data SHALL be unaffected.
REQ-021 Responses have no backpressure; a requester SHALL consume rspN_data in the rspN_valid cycle.
REQ-022 Back-to-back: a requester holding valid high and winning every cycle SHALL receive one response per cycle.
REQ-023 Only one valid: that requester SHALL be granted regardless of last_grant.
REQ-024 Both valid (round-robin mode): requester != last_grant SHALL be granted; last_grant SHALL update to the granted index on every transfer and hold when idle.
REQ-025 Losing requester SHALL keep valid and operands stable until ready; its request SHALL be granted no later than the next cycle in round-robin mode.
REQ-026 Op codes SHALL be passed through unchecked; undefined codes reach the ALU unchanged.

Reset
REQ-027 While rst is high: req0_ready = req1_ready = 0, rsp0_valid = rsp1_valid = 0, grant_id = 0, alu outputs at idle values (REQ-018).
REQ-028 On reset: rsp0_data = rsp1_data = 0; last_grant = 1 so requester 0 wins the first conflict.
REQ-029 rst asserted during a grant cycle SHALL discard that result; no rsp_valid SHALL follow it.

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win conflicts and last_grant SHALL not affect arbitration (requester 1 may starve).
REQ-031 When ALU_ARB_FIXED_PRIO_EN is undefined, round-robin per REQ-024/REQ-025 SHALL apply; all other behaviour is identical in both builds.

Verification
REQ-032 Reset: hold rst 2 cycles with both valids high -> both ready 0, both rsp_valid 0, both rsp_data 0, alu_op = 4'b0000.
REQ-033 Single op: req0 add (op 4'b1000) a=5 b=7 for one cycle -> req0_ready same cycle, alu_op=4'b1000, next cycle rsp0_valid=1 with rsp0_data=12, rsp1_valid=0.
REQ-034 Conflict: req0 sub a=10 b=3, req1 or a=0xF0 b=0x0F, both valid from reset -> cycle 1 grants req0; next cycle rsp0_data=7 and grants req1; following cycle rsp1_data=0xFF.
REQ-035 Fairness: both valid continuously for 8 cycles -> grant_id alternates 0,1,0,1..., 4 responses each.
REQ-036 Fixed priority (macro defined): same stimulus as REQ-035 -> grant_id=0 all 8 cycles, req1_ready never high.
REQ-037 Reset mid-op: req1 slt a=1 b=2 granted, rst high the same cycle -> rsp1_valid stays 0, rsp1_data stays 0.
